// File: rtl/step1_gamma_ao.sv
// One-step POMDP gamma back-up: gamma[a][o][i][s] = discount * sum_s' T*O*alpha, one result
// per handshake, sequenced a -> o -> i -> s (s innermost), one s' term per cycle.
module step1_gamma_ao #(
  parameter int unsigned NS     = 2,
  parameter int unsigned NA     = 3,
  parameter int unsigned NO     = 2,
  parameter int unsigned NALPHA = 16,
  parameter int unsigned W      = 16,
  parameter int unsigned SAT    = 1,
  localparam int unsigned AW    = (NA > 1) ? $clog2(NA) : 1,
  localparam int unsigned OW    = (NO > 1) ? $clog2(NO) : 1,
  localparam int unsigned IW    = (NALPHA > 1) ? $clog2(NALPHA) : 1,
  localparam int unsigned SW    = (NS > 1) ? $clog2(NS) : 1
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  en,
  input  logic [W-1:0]                          discount,
  input  logic [NALPHA-1:0][NS-1:0][W-1:0]      alpha,
  input  logic [NA-1:0][NS-1:0][NS-1:0][W-1:0]  trans,
  input  logic [NA-1:0][NS-1:0][NO-1:0][W-1:0]  observe,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [AW-1:0]                         out_a,
  output logic [OW-1:0]                         out_o,
  output logic [IW-1:0]                         out_i,
  output logic [SW-1:0]                         out_s,
  output logic [W-1:0]                          out_data,
  output logic                                  busy,
  output logic                                  done
);

  localparam int unsigned AccW = W + $clog2(NS);
  localparam int unsigned PW   = $clog2(NS + 1);

  typedef enum logic [1:0] {IDLE, ACC, OUT, FIN} state_t;

  state_t                                 state_q;
  logic [AccW-1:0]                        acc_q;
  logic [PW-1:0]                          ph_q;
  logic [W-1:0]                           disc_q;
  logic [NALPHA-1:0][NS-1:0][W-1:0]       alpha_q;
  logic [NA-1:0][NS-1:0][NS-1:0][W-1:0]   trans_q;
  logic [NA-1:0][NS-1:0][NO-1:0][W-1:0]   observe_q;

  logic [SW-1:0]   sp;
  logic [2*W-1:0]  prod1, prod2, prod3;
  logic [W-1:0]    p1, p2, acc_clip;
  logic [AccW-1:0] acc_max;
  logic            last;

  // ph_q == NS is the discount cycle; the s' index it aliases is never accumulated.
  assign sp      = ph_q[SW-1:0];
  assign acc_max = AccW'({W{1'b1}});
  assign last    = (out_a == AW'(NA - 1)) && (out_o == OW'(NO - 1)) &&
                   (out_i == IW'(NALPHA - 1)) && (out_s == SW'(NS - 1));

  always_comb begin
    prod1    = (2*W)'(trans_q[out_a][out_s][sp]) * (2*W)'(observe_q[out_a][sp][out_o]);
    p1       = prod1[2*W-1:W];
    prod2    = (2*W)'(p1) * (2*W)'(alpha_q[out_i][sp]);
    p2       = prod2[2*W-1:W];
    acc_clip = ((SAT != 0) && (acc_q > acc_max)) ? {W{1'b1}} : acc_q[W-1:0];
    prod3    = (2*W)'(acc_clip) * (2*W)'(disc_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_a     <= '0;
      out_o     <= '0;
      out_i     <= '0;
      out_s     <= '0;
      acc_q     <= '0;
      ph_q      <= '0;
      disc_q    <= '0;
      alpha_q   <= '0;
      trans_q   <= '0;
      observe_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (en) begin
            disc_q    <= discount;
            alpha_q   <= alpha;
            trans_q   <= trans;
            observe_q <= observe;
            busy      <= 1'b1;
            out_a     <= '0;
            out_o     <= '0;
            out_i     <= '0;
            out_s     <= '0;
            acc_q     <= '0;
            ph_q      <= '0;
            state_q   <= ACC;
          end
        end
        ACC: begin
          if (ph_q != PW'(NS)) begin
            acc_q <= acc_q + AccW'(p2);
            ph_q  <= ph_q + PW'(1);
          end else begin
            out_data  <= prod3[2*W-1:W];
            out_valid <= 1'b1;
            state_q   <= OUT;
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (last) begin
              done    <= 1'b1;
              state_q <= FIN;
            end else begin
              acc_q   <= '0;
              ph_q    <= '0;
              state_q <= ACC;
              if (out_s == SW'(NS - 1)) begin
                out_s <= '0;
                if (out_i == IW'(NALPHA - 1)) begin
                  out_i <= '0;
                  if (out_o == OW'(NO - 1)) begin
                    out_o <= '0;
                    out_a <= out_a + AW'(1);
                  end else begin
                    out_o <= out_o + OW'(1);
                  end
                end else begin
                  out_i <= out_i + IW'(1);
                end
              end else begin
                out_s <= out_s + SW'(1);
              end
            end
          end
        end
        FIN: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_step1_gamma_ao.sv
// Bench for step1_gamma_ao: table vectors, stall/poke/reset sequences and random runs, all
// checked against an arithmetic model of the gamma back-up.
module tb_step1_gamma_ao;
  localparam int NS = 2, NA = 3, NO = 2, NAL = 16, NAL2 = 8, W = 16;

  logic clk = 1'b0, rst = 1'b0, en = 1'b0, out_ready = 1'b0;
  logic [W-1:0]                          discount;
  logic [NAL-1:0][NS-1:0][W-1:0]         alpha_p;
  logic [NA-1:0][NS-1:0][NS-1:0][W-1:0]  trans_p;
  logic [NA-1:0][NS-1:0][NO-1:0][W-1:0]  obs_p;

  logic        v [3];
  logic        busy [3];
  logic        done [3];
  logic [15:0] data [3];
  logic [1:0]  oa [3];
  logic [0:0]  oo [3];
  logic [3:0]  oi [2];
  logic [2:0]  oi2;
  logic [0:0]  os [3];

  always #5 clk = ~clk;

  // dut 0: defaults (SAT=1); dut 1: wrapping; dut 2: 8 alpha vectors (96 results per run)
  step1_gamma_ao #(.NS(NS), .NA(NA), .NO(NO), .NALPHA(NAL), .W(W), .SAT(1)) u_sat (
    .clk(clk), .rst(rst), .en(en), .discount(discount), .alpha(alpha_p), .trans(trans_p),
    .observe(obs_p), .out_valid(v[0]), .out_ready(out_ready), .out_a(oa[0]), .out_o(oo[0]),
    .out_i(oi[0]), .out_s(os[0]), .out_data(data[0]), .busy(busy[0]), .done(done[0]));
  step1_gamma_ao #(.NS(NS), .NA(NA), .NO(NO), .NALPHA(NAL), .W(W), .SAT(0)) u_wrap (
    .clk(clk), .rst(rst), .en(en), .discount(discount), .alpha(alpha_p), .trans(trans_p),
    .observe(obs_p), .out_valid(v[1]), .out_ready(out_ready), .out_a(oa[1]), .out_o(oo[1]),
    .out_i(oi[1]), .out_s(os[1]), .out_data(data[1]), .busy(busy[1]), .done(done[1]));
  step1_gamma_ao #(.NS(NS), .NA(NA), .NO(NO), .NALPHA(NAL2), .W(W), .SAT(1)) u_small (
    .clk(clk), .rst(rst), .en(en), .discount(discount), .alpha(alpha_p[NAL2-1:0]),
    .trans(trans_p), .observe(obs_p), .out_valid(v[2]), .out_ready(out_ready), .out_a(oa[2]),
    .out_o(oo[2]), .out_i(oi2), .out_s(os[2]), .out_data(data[2]), .busy(busy[2]),
    .done(done[2]));

  int n_chk = 0, n_fail = 0;
  int unsigned tr [NA][NS][NS];
  int unsigned ob [NA][NS][NO];
  int unsigned al [NAL][NS];
  int unsigned disc_m;

  typedef struct {
    logic [15:0] disc, tfill, ofill, afill;
    int          kind;   // 0 plain fill, 1 fill + alpha[0] override, 2 identity layout
    int          target;
    longint      e_sat, e_wrap;
  } vec_t;

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic longint model(int a, int o, int i, int s, bit sat);
    longint acc = 0, p1, p2;
    for (int sp = 0; sp < NS; sp++) begin
      p1 = (longint'(tr[a][s][sp]) * longint'(ob[a][sp][o])) >> 16;
      p2 = (p1 * longint'(al[i][sp])) >> 16;
      acc += p2;
    end
    if (sat) acc = (acc > 65535) ? 65535 : acc;
    else acc = acc % 65536;
    return (acc * longint'(disc_m)) >> 16;
  endfunction

  task automatic drive();
    discount = disc_m[15:0];
    for (int a = 0; a < NA; a++)
      for (int s = 0; s < NS; s++) begin
        for (int sp = 0; sp < NS; sp++) trans_p[a][s][sp] = tr[a][s][sp][15:0];
        for (int o = 0; o < NO; o++) obs_p[a][s][o] = ob[a][s][o][15:0];
      end
    for (int i = 0; i < NAL; i++)
      for (int sp = 0; sp < NS; sp++) alpha_p[i][sp] = al[i][sp][15:0];
  endtask

  task automatic garble();
    discount = 16'($urandom);
    for (int a = 0; a < NA; a++)
      for (int s = 0; s < NS; s++) begin
        for (int sp = 0; sp < NS; sp++) trans_p[a][s][sp] = 16'($urandom);
        for (int o = 0; o < NO; o++) obs_p[a][s][o] = 16'($urandom);
      end
    for (int i = 0; i < NAL; i++)
      for (int sp = 0; sp < NS; sp++) alpha_p[i][sp] = 16'($urandom);
  endtask

  task automatic setup(input vec_t r);
    disc_m = r.disc;
    for (int a = 0; a < NA; a++)
      for (int s = 0; s < NS; s++) begin
        for (int sp = 0; sp < NS; sp++) tr[a][s][sp] = (r.kind == 2) ? 0 : r.tfill;
        for (int o = 0; o < NO; o++) ob[a][s][o] = (r.kind == 2) ? 0 : r.ofill;
      end
    for (int i = 0; i < NAL; i++)
      for (int sp = 0; sp < NS; sp++) al[i][sp] = r.afill;
    if (r.kind >= 1) begin
      al[0][0] = 13464;
      al[0][1] = 20673;
    end
    if (r.kind == 2) begin
      tr[2][0][0] = 16'hFFFF;
      tr[2][1][1] = 16'hFFFF;
      ob[2][0][0] = 55706;
    end
    drive();
  endtask

  task automatic setup_random();
    disc_m = $urandom_range(0, 65535);
    for (int a = 0; a < NA; a++)
      for (int s = 0; s < NS; s++) begin
        for (int sp = 0; sp < NS; sp++) tr[a][s][sp] = $urandom_range(0, 65535);
        for (int o = 0; o < NO; o++) ob[a][s][o] = $urandom_range(0, 65535);
      end
    for (int i = 0; i < NAL; i++)
      for (int sp = 0; sp < NS; sp++) al[i][sp] = $urandom_range(0, 65535);
    drive();
  endtask

  function automatic int idx_code(int k);
    int iv = (k == 2) ? int'(oi2) : int'(oi[k]);
    return int'(oa[k]) * 4096 + int'(oo[k]) * 256 + iv * 16 + int'(os[k]);
  endfunction

  // Called at a negedge; raises en and returns once dut 0 shows its first result.
  task automatic start();
    int lat = 0;
    en = 1'b1;
    out_ready = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) begin
        en = 1'b0;
        check("busy_after_en", busy[0], 1);
      end
      if (v[0]) begin
        lat = k;
        break;
      end
    end
    check("first_valid_latency", lat, NS + 2);
  endtask

  task automatic run(input int target, input longint e_sat, input longint e_wrap,
                     input bit rnd, input bit stall, input bit scramble, input bit poke);
    int idx [3] = '{0, 0, 0};
    int dn [3] = '{0, 0, 0};
    int total [3] = '{NA * NO * NAL * NS, NA * NO * NAL * NS, NA * NO * NAL2 * NS};
    int cyc = 0, stall_left = stall ? 10 : 0, nal, a, o, i, s;
    bit fin0 = 0, fin2 = 0, snapped = 0;
    longint snap_d, snap_i;
    while (!(fin0 && fin2) && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (scramble && cyc == 3) garble();
      en = (poke && cyc == 7) ? 1'b1 : 1'b0;
      if (stall_left > 0 && v[0]) begin
        if (!snapped) begin
          snap_d = data[0];
          snap_i = idx_code(0);
          snapped = 1;
        end else begin
          check("stall_valid_held", v[0], 1);
          check("stall_data_stable", data[0], snap_d);
          check("stall_index_stable", idx_code(0), snap_i);
        end
        out_ready = 1'b0;
        stall_left--;
      end else begin
        out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      for (int k = 0; k < 3; k++) begin
        if (v[k] && out_ready) begin
          nal = (k == 2) ? NAL2 : NAL;
          s = idx[k] % NS;
          i = (idx[k] / NS) % nal;
          o = (idx[k] / (NS * nal)) % NO;
          a = idx[k] / (NS * nal * NO);
          check($sformatf("dut%0d_index", k), idx_code(k), a * 4096 + o * 256 + i * 16 + s);
          check($sformatf("dut%0d_data", k), data[k], model(a, o, i, s, k != 1));
          if (k == 0 && idx[k] == target) check("table_sat", data[k], e_sat);
          if (k == 1 && idx[k] == target) check("table_wrap", data[k], e_wrap);
          idx[k]++;
        end
        if (done[k]) begin
          dn[k]++;
          check($sformatf("dut%0d_count_at_done", k), idx[k], total[k]);
          if (k == 0) fin0 = 1;
          if (k == 2) fin2 = 1;
        end
      end
    end
    en = 1'b0;
    check("run_finished", int'(fin0 & fin2), 1);
    for (int k = 0; k < 3; k++) check($sformatf("dut%0d_done_pulses", k), dn[k], 1);
    @(negedge clk);
    check("done_one_cycle", done[0], 0);
    check("busy_clear_after_fin", busy[0], 0);
    check("no_valid_after_fin", v[0], 0);
  endtask

  vec_t tbl [3];

  initial begin
    tbl[0] = '{disc: 16'hC000, tfill: 16'h8000, ofill: 16'h8000, afill: 16'h0000, kind: 1,
               target: 0, e_sat: 6400, e_wrap: 6400};
    tbl[1] = '{disc: 16'hFFFF, tfill: 16'hFFFF, ofill: 16'hFFFF, afill: 16'hFFFF, kind: 0,
               target: 0, e_sat: 65534, e_wrap: 65529};
    // (a2,o0,i0,s0) is result number 2*NO*NAL*NS
    tbl[2] = '{disc: 16'hC000, tfill: 16'h0000, ofill: 16'h0000, afill: 16'h0000, kind: 2,
               target: 2 * NO * NAL * NS, e_sat: 8583, e_wrap: 8583};
    setup(tbl[0]);

    #1 rst = 1'b1;
    #2;
    check("reset_valid", v[0], 0);
    check("reset_busy", busy[0], 0);
    check("reset_done", done[0], 0);
    check("reset_data", data[0], 0);
    check("reset_index", idx_code(0), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    foreach (tbl[r]) begin
      setup(tbl[r]);
      start();
      run(tbl[r].target, tbl[r].e_sat, tbl[r].e_wrap, 0, 0, 0, 0);
    end

    // Output stall, inputs changed while busy, and a stray en mid-run.
    setup_random();
    start();
    run(-1, 0, 0, 1, 1, 1, 1);

    // Reset during ACC abandons the run; the next en right after release is honoured.
    setup(tbl[2]);
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_valid", v[0], 0);
    check("midrst_busy", busy[0], 0);
    check("midrst_done", done[0], 0);
    check("midrst_data", data[0], 0);
    check("midrst_index", idx_code(0), 0);
    @(negedge clk);
    check("midrst_no_done", done[0], 0);
    rst = 1'b0;
    start();
    run(tbl[2].target, tbl[2].e_sat, tbl[2].e_wrap, 0, 0, 0, 0);

    for (int n = 0; n < 2; n++) begin
      setup_random();
      start();
      run(-1, 0, 0, 1, 0, 0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL global_timeout: got 0, expected 1");
    $fatal(1, "timeout");
  end

endmodule
